// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
// Shared definitions for the FIFO-fed UART transmitter: default frame
// geometry, the transmitter FSM state encoding and a counter-width helper.
package fifo_uart_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_START   = 3'd3,
    ST_DATA    = 3'd4,
    ST_STOP    = 3'd5
  } state_t;

  // Width of a counter covering 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if
// Read-side handshake between a synchronous FIFO and the UART transmitter.
//   fifo_empty   : FIFO empty flag (combinational on the FIFO side)
//   fifo_rd_data : read data, valid the cycle after fifo_rd_en is sampled
//   fifo_rd_en   : pop request from the transmitter
// Modports: master = transmitter (pops), slave = FIFO (serves pops).
interface fifo_uart_tx_if #(
  parameter int WIDTH = fifo_uart_pkg::DEF_WIDTH
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt
// Per-bit cycle counter. Counts 0..CLKS_PER_BIT-1 while run_i is high and
// wraps to 0 on each bit boundary; held at 0 while run_i is low.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   run_i        : count enable (frame in progress)
//   cnt_o        : current position within the bit
//   bit_tick_o   : high on the last cycle of each bit
module uart_baud_cnt
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int CW           = cnt_width(CLKS_PER_BIT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          run_i,
  output logic [CW-1:0] cnt_o,
  output logic          bit_tick_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign bit_tick_o = run_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pops one word per frame from a FIFO and sends it as a UART frame:
// one start bit (0), WIDTH data bits LSB first, one stop bit (1), no parity.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   enable_i     : permits new frames; only looked at on frame boundaries
//   fifo_if      : FIFO read handshake (master side)
//   tx_o         : serial line, idle high, registered
//   busy_o       : high whenever the FSM is not in IDLE
//   done_o       : one-cycle pulse on the last cycle of each stop bit
//
// state   | meaning
// IDLE    | line high, waiting for enable and a non-empty FIFO
// FETCH   | fifo_rd_en high for one cycle
// CAPTURE | FIFO data now valid, loaded into the shift register
// START   | start bit (0)
// DATA    | shift register bit 0 on the line, WIDTH bits
// STOP    | stop bit (1); done pulses on its last cycle
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           enable_i,
  fifo_uart_tx_if.master fifo_if,
  output logic           tx_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int BW = cnt_width(WIDTH);

  // done is registered, so it is armed one cycle before the stop bit ends.
  localparam logic [CW-1:0] DONE_PRE = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             tx_q, tx_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  // Blocks a pop on the first edge after reset release.
  logic             armed_q, armed_d;

  logic [CW-1:0]    baud_cnt;
  logic             bit_tick;
  logic             baud_run;
  logic             start_ok;
  logic [WIDTH-1:0] shreg_shift;

  assign baud_run    = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_STOP);
  assign start_ok    = enable_i && !fifo_if.fifo_empty;
  assign shreg_shift = shreg_q >> 1;

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CW           (CW)
  ) u_baud_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .run_i      (baud_run),
    .cnt_o      (baud_cnt),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rd_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    armed_d   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (armed_q && start_ok) begin
          state_d = ST_FETCH;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      ST_FETCH: begin
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        shreg_d = fifo_if.fifo_rd_data;
        state_d = ST_START;
        tx_d    = 1'b0;
      end

      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_d      = shreg_q[0];
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          shreg_d = shreg_shift;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            tx_d      = shreg_shift[0];
          end
        end
      end

      ST_STOP: begin
        if (baud_cnt == DONE_PRE) begin
          done_d = 1'b1;
        end
        if (bit_tick) begin
          if (start_ok) begin
            state_d = ST_FETCH;
            rd_en_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      armed_q   <= armed_d;
    end
  end

  assign fifo_if.fifo_rd_en = rd_en_q;
  assign tx_o               = tx_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Directed bench for fifo_uart_tx with WIDTH=8, CLKS_PER_BIT=4 and a small
// FIFO model. Outputs are sampled on the falling edge.
module tb_fifo_uart_tx;

  localparam int W   = 8;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic tx;
  logic busy;
  logic done;

  int n_tests  = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int done_cnt = 0;

  logic [7:0] mem [16];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;

  fifo_uart_tx_if #(.WIDTH(W)) fifo_if ();

  assign fifo_if.fifo_empty = (wr_ptr == rd_ptr);

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .WIDTH        (W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (enable),
    .fifo_if  (fifo_if),
    .tx_o     (tx),
    .busy_o   (busy),
    .done_o   (done)
  );

  // FIFO model: data appears the cycle after rd_en is sampled high.
  always @(posedge clk) begin
    if (fifo_if.fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_if.fifo_rd_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 4'd1;
    end
  end

  always @(posedge clk) begin
    if (fifo_if.fifo_rd_en) rd_cnt++;
    if (done) done_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  // Samples one full frame starting at the first start-bit cycle.
  task automatic expect_frame(input logic [7:0] b, input string tag,
                              input bit drop_en);
    logic [3:0] nib;
    logic [3:0] dn;
    logic       exp_bit;
    logic       early_done;
    early_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      exp_bit = 1'b0;
      else if (i == 9) exp_bit = 1'b1;
      else             exp_bit = b[i-1];
      nib = '0;
      dn  = '0;
      for (int c = 0; c < CPB; c++) begin
        step();
        nib[c] = tx;
        dn[c]  = done;
        if (drop_en && (i == 0) && (c == 1)) enable = 1'b0;
      end
      check_val($sformatf("%s_bit%0d", tag, i), {28'd0, nib},
                exp_bit ? 32'hF : 32'h0);
      if (i == 9) check_val({tag, "_done"}, {28'd0, dn}, 32'h8);
      else if (dn != 4'b0000) early_done = 1'b1;
    end
    check_val({tag, "_early_done"}, {31'd0, early_done}, 32'd0);
  endtask

  initial begin
    logic       any_rd, any_low, any_busy;
    logic [1:0] gap_tx, gap_rd;
    int         d0, r0;

    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) step();
    check_val("rst_tx",    {31'd0, tx},                 32'd1);
    check_val("rst_busy",  {31'd0, busy},               32'd0);
    check_val("rst_rd_en", {31'd0, fifo_if.fifo_rd_en}, 32'd0);
    check_val("rst_done",  {31'd0, done},               32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Single frame 0xA5
    enable = 1'b1;
    push(8'hA5);
    step();
    check_val("t1_fetch_rd_en", {31'd0, fifo_if.fifo_rd_en}, 32'd1);
    check_val("t1_fetch_busy",  {31'd0, busy},               32'd1);
    check_val("t1_fetch_tx",    {31'd0, tx},                 32'd1);
    step();
    check_val("t1_capt_rd_en",  {31'd0, fifo_if.fifo_rd_en}, 32'd0);
    check_val("t1_capt_tx",     {31'd0, tx},                 32'd1);
    expect_frame(8'hA5, "t1", 1'b0);
    step();
    check_val("t1_idle_busy", {31'd0, busy}, 32'd0);
    check_val("t1_rd_cnt",    rd_cnt,        32'd1);
    check_val("t1_done_cnt",  done_cnt,      32'd1);

    // Back-to-back 0x55, 0x0F
    push(8'h55);
    push(8'h0F);
    step();
    check_val("t2_fetch_rd_en", {31'd0, fifo_if.fifo_rd_en}, 32'd1);
    step();
    expect_frame(8'h55, "t2a", 1'b0);
    step();
    gap_tx[0] = tx;
    gap_rd[0] = fifo_if.fifo_rd_en;
    step();
    gap_tx[1] = tx;
    gap_rd[1] = fifo_if.fifo_rd_en;
    check_val("t2_gap_tx", {30'd0, gap_tx}, 32'h3);
    check_val("t2_gap_rd", {30'd0, gap_rd}, 32'h1);
    expect_frame(8'h0F, "t2b", 1'b0);
    step();
    check_val("t2_idle_busy", {31'd0, busy}, 32'd0);
    check_val("t2_rd_cnt",    rd_cnt,        32'd3);
    check_val("t2_done_cnt",  done_cnt,      32'd3);

    // Empty FIFO with enable held high
    any_rd   = 1'b0;
    any_low  = 1'b0;
    any_busy = 1'b0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (fifo_if.fifo_rd_en) any_rd = 1'b1;
      if (!tx) any_low = 1'b1;
      if (busy) any_busy = 1'b1;
    end
    check_val("t3_rd_en", {31'd0, any_rd},   32'd0);
    check_val("t3_tx",    {31'd0, any_low},  32'd0);
    check_val("t3_busy",  {31'd0, any_busy}, 32'd0);

    // Reset during the third data bit of 0x38, then 0x81 goes out
    push(8'h38);
    push(8'h81);
    step();
    check_val("t4_fetch_rd_en", {31'd0, fifo_if.fifo_rd_en}, 32'd1);
    step();
    repeat (14) step();
    check_val("t4_pre_tx", {31'd0, tx}, 32'd0);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check_val("t4_rst_tx",   {31'd0, tx},   32'd1);
    check_val("t4_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) step();
    check_val("t4_no_done", done_cnt, d0);
    rst = 1'b0;
    step();
    check_val("t4_rel1_rd_en", {31'd0, fifo_if.fifo_rd_en}, 32'd0);
    step();
    check_val("t4_rel2_rd_en", {31'd0, fifo_if.fifo_rd_en}, 32'd1);
    step();
    expect_frame(8'h81, "t4", 1'b0);
    step();
    check_val("t4_idle_busy", {31'd0, busy}, 32'd0);
    check_val("t4_done_cnt",  done_cnt,      d0 + 1);

    // Enable dropped during START with two words queued
    push(8'h12);
    push(8'h34);
    step();
    check_val("t5_fetch_rd_en", {31'd0, fifo_if.fifo_rd_en}, 32'd1);
    step();
    expect_frame(8'h12, "t5a", 1'b1);
    step();
    check_val("t5_idle_busy", {31'd0, busy}, 32'd0);
    r0 = rd_cnt;
    any_rd = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (fifo_if.fifo_rd_en) any_rd = 1'b1;
    end
    check_val("t5_hold_rd_en", {31'd0, any_rd},  32'd0);
    check_val("t5_hold_cnt",   rd_cnt,           r0);
    check_val("t5_fifo_level", {28'd0, 4'(wr_ptr - rd_ptr)}, 32'd1);
    enable = 1'b1;
    step();
    check_val("t5_resume_rd_en", {31'd0, fifo_if.fifo_rd_en}, 32'd1);
    step();
    expect_frame(8'h34, "t5b", 1'b0);
    step();
    check_val("t5_end_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
